spi_frame_seq: RTL
==================

// Module: spi_frame_seq
// PURPOSE
//  Multi-byte frame sequencer for the byte-level spi_master. Takes a frame request (byte count),
//  pulls TX bytes over a valid/ready handshake, issues one spi_master write per byte, returns RX
//  bytes, and owns chip-select timing (setup, inter-byte gap, hold) across the whole frame.
//  Sits between the register/command logic and spi_master; sole driver of spi_master control inputs.
// PARAMETERS
//  LEN_W        8         width of frame byte count
//  CS_SETUP     4         sys_clk cycles from CS low to first byte request (0 allowed)
//  BYTE_GAP     2         cycles between ack and next byte fetch; values <2 are treated as 2
//  CS_HOLD      4         cycles from last ack to CS high; values <2 are treated as 2
//  TIMEOUT_CYC  24'hFFFFFF  cycles in WAIT_ACK before abort (SPI_SEQ_TIMEOUT_EN only)
// PORTS
//  sys_clk      in   1      clock
//  sys_rst_n    in   1      async active-low reset
//  start        in   1      frame request, sampled only in IDLE
//  len          in   LEN_W  bytes in frame, latched with start
//  busy         out  1      high from the cycle after accepted start until DONE exits
//  done         out  1      1-cycle pulse at frame end
//  err          out  1      1-cycle pulse with done on timeout abort; constant 0 without macro
//  tx_data      in   8      next byte to send
//  tx_valid     in   1      tx_data valid
//  tx_ready     out  1      high in FETCH only; transfer when tx_valid & tx_ready
//  rx_data      out  8      received byte
//  rx_valid     out  1      1-cycle pulse, rx_data valid
//  spi_cs_ctrl  out  1      to spi_master cs_ctrl; 1 = deselected
//  spi_wr_req   out  1      to spi_master wr_req
//  spi_wr_ack   in   1      from spi_master wr_ack (1-cycle pulse)
//  spi_data_tx  out  8      to spi_master data_tx, stable from REQ until ack
//  spi_data_rx  in   8      from spi_master data_rx, sampled on spi_wr_ack
// BEHAVIOUR
//  Reset: state IDLE; spi_cs_ctrl=1; busy, done, err, tx_ready, rx_valid, spi_wr_req = 0;
//   rx_data, spi_data_tx = 0; counters 0. Reset mid-frame takes effect immediately (async);
//   spi_master shares sys_rst_n, so no partial byte survives.
//  States: IDLE, SETUP, FETCH, REQ, WAIT_ACK, GAP, HOLD, DONE.
//  IDLE: start & len!=0 -> latch len to remaining, SETUP, CS low. start & len==0 -> DONE, CS stays high.
//   start outside IDLE is ignored; len is ignored after latch.
//  SETUP: hold CS_SETUP cycles (CS_SETUP=0: one pass-through cycle) -> FETCH.
//  FETCH: tx_ready=1; on tx_valid: spi_data_tx<=tx_data -> REQ. Stall unbounded; CS stays low.
//  REQ: spi_wr_req=1 for exactly one cycle -> WAIT_ACK.
//  WAIT_ACK: on spi_wr_ack: rx_data<=spi_data_rx, rx_valid=1 next cycle, remaining-1;
//   remaining was 1 -> HOLD else GAP. Ack outside WAIT_ACK is ignored.
//  GAP: max(BYTE_GAP,2) cycles -> FETCH (covers spi_master FINISH->IDLE return).
//  HOLD: max(CS_HOLD,2) cycles -> DONE.
//  DONE: CS high, done=1 one cycle, busy drops with it -> IDLE. Min CS-high time = 1 cycle.
//  remaining is LEN_W bits; len=2^LEN_W-1 is the maximum frame; no wrap.
// CONFIGURATION
//  SPI_SEQ_TIMEOUT_EN defined: 24-bit counter in WAIT_ACK; at TIMEOUT_CYC without ack ->
//   DONE with err=1 alongside done; no rx_valid for that byte; remaining bytes discarded.
//  Not defined: no counter; WAIT_ACK waits indefinitely; err tied 0.
// TESTING (bench: this block + spi_master CPOL=1 CPHA=1, clk_div_val=2, miso looped to mosi)
//  len=3, tx A5,3C,FF always valid -> 3 spi_wr_req pulses, rx A5,3C,FF, CS low continuously, 1 done.
//  len=0 -> done 1 cycle after start, err=0, CS never low, no spi_wr_req, no tx_ready.
//  len=2, tx_valid withheld 50 cycles before byte 2 -> CS low throughout, no req during stall, rx correct.
//  start pulsed mid-frame with len=9 -> ignored; frame completes with original length, single done.
//  sys_rst_n low during WAIT_ACK -> CS high, busy 0, req 0 same cycle; new len=1 frame then passes.
//  SPI_SEQ_TIMEOUT_EN, TIMEOUT_CYC=100, ack forced 0 -> done+err 100 cycles after REQ; without macro busy stays 1.

Source files
------------

// File: rtl/spi_frame_seq.sv
// Multi-byte frame sequencer in front of the byte-level spi_master: fetches TX bytes, issues one
// write per byte, returns RX bytes and owns CS timing. Optional abort timer: SPI_SEQ_TIMEOUT_EN.
module spi_frame_seq #(
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned BYTE_GAP = 2,
  parameter int unsigned CS_HOLD  = 4
`ifdef SPI_SEQ_TIMEOUT_EN
  ,
  parameter logic [23:0] TIMEOUT_CYC = 24'hFFFFFF
`endif
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_ni,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  input  logic [7:0]       tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  output logic             spi_cs_ctrl_o,
  output logic             spi_wr_req_o,
  input  logic             spi_wr_ack_i,
  output logic [7:0]       spi_data_tx_o,
  input  logic [7:0]       spi_data_rx_i
);

  // Gap and hold never go below 2 so spi_master has time to return to idle.
  localparam int unsigned SetupCyc = (CS_SETUP == 0) ? 1 : CS_SETUP;
  localparam int unsigned GapCyc   = (BYTE_GAP < 2) ? 2 : BYTE_GAP;
  localparam int unsigned HoldCyc  = (CS_HOLD < 2) ? 2 : CS_HOLD;
  localparam int unsigned MaxSg    = (SetupCyc > GapCyc) ? SetupCyc : GapCyc;
  localparam int unsigned CntMax   = (MaxSg > HoldCyc) ? MaxSg : HoldCyc;
  localparam int unsigned CntW     = $clog2(CntMax);

  localparam logic [CntW-1:0] SetupLast = CntW'(SetupCyc - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(GapCyc - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(HoldCyc - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StFetch,
    StReq,
    StWaitAck,
    StGap,
    StHold,
    StDone
  } state_e;

  state_e           state_q;
  logic [LEN_W-1:0] remaining_q;
  logic [CntW-1:0]  cnt_q;
  logic             cs_q;
  logic             busy_q;
  logic             done_q;
  logic             tx_ready_q;
  logic             rx_valid_q;
  logic             wr_req_q;
  logic [7:0]       rx_data_q;
  logic [7:0]       data_tx_q;
  logic             last_byte;

  assign last_byte = (remaining_q == LEN_W'(1));

`ifdef SPI_SEQ_TIMEOUT_EN
  logic [23:0] to_cnt_q;
  logic        err_q;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      cnt_q       <= '0;
      cs_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tx_ready_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      wr_req_q    <= 1'b0;
      rx_data_q   <= 8'h00;
      data_tx_q   <= 8'h00;
`ifdef SPI_SEQ_TIMEOUT_EN
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            if (len_i != '0) begin
              remaining_q <= len_i;
              cs_q        <= 1'b0;
              state_q     <= StSetup;
            end else begin
              // Empty frame: report completion without ever selecting the slave.
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end

        StSetup: begin
          if (cnt_q == SetupLast) begin
            cnt_q      <= '0;
            tx_ready_q <= 1'b1;
            state_q    <= StFetch;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StFetch: begin
          if (tx_valid_i) begin
            data_tx_q  <= tx_data_i;
            tx_ready_q <= 1'b0;
            wr_req_q   <= 1'b1;
            state_q    <= StReq;
          end
        end

        StReq: begin
          wr_req_q <= 1'b0;
          state_q  <= StWaitAck;
`ifdef SPI_SEQ_TIMEOUT_EN
          // Counts cycles elapsed since the request cycle.
          to_cnt_q <= 24'd1;
`endif
        end

        StWaitAck: begin
          if (spi_wr_ack_i) begin
            rx_data_q   <= spi_data_rx_i;
            rx_valid_q  <= 1'b1;
            remaining_q <= remaining_q - 1'b1;
            cnt_q       <= '0;
            state_q     <= last_byte ? StHold : StGap;
          end
`ifdef SPI_SEQ_TIMEOUT_EN
          else if (to_cnt_q >= TIMEOUT_CYC - 24'd1) begin
            remaining_q <= '0;
            cs_q        <= 1'b1;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            state_q     <= StDone;
          end else begin
            to_cnt_q <= to_cnt_q + 24'd1;
          end
`endif
        end

        StGap: begin
          if (cnt_q == GapLast) begin
            cnt_q      <= '0;
            tx_ready_q <= 1'b1;
            state_q    <= StFetch;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StHold: begin
          if (cnt_q == HoldLast) begin
            cnt_q   <= '0;
            cs_q    <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign tx_ready_o    = tx_ready_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign spi_cs_ctrl_o = cs_q;
  assign spi_wr_req_o  = wr_req_q;
  assign spi_data_tx_o = data_tx_q;

endmodule
